// File: rtl/bf_pkg.sv
// Shared definitions for the bfX core: opcode bytes and loop-unit states.
package bf_pkg;

    localparam logic [7:0] OP_INC    = 8'h2B;
    localparam logic [7:0] OP_DEC    = 8'h2D;
    localparam logic [7:0] OP_LEFT   = 8'h3C;
    localparam logic [7:0] OP_RIGHT  = 8'h3E;
    localparam logic [7:0] OP_OUT    = 8'h2E;
    localparam logic [7:0] OP_IN     = 8'h2C;
    localparam logic [7:0] OP_LBRACK = 8'h5B;
    localparam logic [7:0] OP_RBRACK = 8'h5D;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_SKIP = 2'd1,
        ST_ERR  = 2'd2
    } loop_state_t;

endpackage

// File: rtl/bf_loop_stack.sv
// Register LIFO of open-loop addresses; top reads combinationally.
module bf_loop_stack
    import bf_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [ADDR_W-1:0]          din,
    output logic [ADDR_W-1:0]          top,
    output logic [$clog2(DEPTH):0]     depth,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int DW = AW + 1;

    logic [ADDR_W-1:0] mem [DEPTH];
    logic [DW-1:0]     sp;
    logic [AW-1:0]     wr_idx;
    logic [AW-1:0]     rd_idx;

    assign wr_idx = sp[AW-1:0];
    assign rd_idx = wr_idx - AW'(1);
    assign full   = (sp == DW'(DEPTH));
    assign empty  = (sp == '0);
    assign depth  = sp;
    assign top    = empty ? '0 : mem[rd_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            sp <= '0;
        end else if (push && !full) begin
            sp <= sp + DW'(1);
        end else if (pop && !empty) begin
            sp <= sp - DW'(1);
        end
    end

    // Storage needs no reset: entries above sp are never read.
    always_ff @(posedge clk) begin
        if (push && !full && !rst) begin
            mem[wr_idx] <= din;
        end
    end

endmodule

// File: rtl/bf_loop_unit.sv
// Loop-control stage: bracket decode, forward skip, loop stack, PC select.
module bf_loop_unit
    import bf_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       instr_valid,
    input  logic [7:0]                 instr,
    input  logic [ADDR_W-1:0]          pc,
    input  logic                       cell_is_zero,
    output logic                       jump,
    output logic [ADDR_W-1:0]          jump_target,
    output logic                       skip,
    output logic [$clog2(DEPTH):0]     depth,
    output logic                       err_overflow,
    output logic                       err_underflow
);

    loop_state_t       state, state_n;
    logic [ADDR_W-1:0] skip_cnt, skip_cnt_n;
    logic              push, pop;
    logic              set_ovf, set_udf;
    logic              is_lb, is_rb;
    logic [ADDR_W-1:0] top;
    logic              full, empty;

    assign is_lb = instr_valid && (instr == OP_LBRACK);
    assign is_rb = instr_valid && (instr == OP_RBRACK);

    bf_loop_stack #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_stack (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (pc),
        .top   (top),
        .depth (depth),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_RUN;
            skip_cnt      <= '0;
            err_overflow  <= 1'b0;
            err_underflow <= 1'b0;
        end else begin
            state    <= state_n;
            skip_cnt <= skip_cnt_n;
            if (set_ovf) err_overflow  <= 1'b1;
            if (set_udf) err_underflow <= 1'b1;
        end
    end

    always_comb begin
        state_n    = state;
        skip_cnt_n = skip_cnt;
        push       = 1'b0;
        pop        = 1'b0;
        set_ovf    = 1'b0;
        set_udf    = 1'b0;
        jump       = 1'b0;
        case (state)
            ST_RUN: begin
                unique case (1'b1)
                    is_lb: begin
                        if (cell_is_zero) begin
                            state_n    = ST_SKIP;
                            skip_cnt_n = ADDR_W'(1);
                        end else if (full) begin
                            set_ovf = 1'b1;
                            state_n = ST_ERR;
                        end else begin
                            push = 1'b1;
                        end
                    end
                    is_rb: begin
                        if (empty) begin
                            set_udf = 1'b1;
                            state_n = ST_ERR;
                        end else if (!cell_is_zero) begin
                            jump = 1'b1;
                        end else begin
                            pop = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
            ST_SKIP: begin
                unique case (1'b1)
                    is_lb: skip_cnt_n = skip_cnt + ADDR_W'(1);
                    is_rb: begin
                        skip_cnt_n = skip_cnt - ADDR_W'(1);
                        if (skip_cnt == ADDR_W'(1)) state_n = ST_RUN;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    assign jump_target = empty ? '0 : top + ADDR_W'(1);
    assign skip        = (state != ST_RUN) || is_lb || is_rb;

endmodule

// File: doc/bf_loop_unit.md
# bf_loop_unit

Loop-control stage for the bfX core. Sits directly upstream of the 16-bit program-counter mux. It decodes `[`/`]` from the fetched instruction byte, keeps a stack of open-loop addresses and a nesting counter for forward skips, and drives the PC-source select and jump target. Its outputs feed the `sel` and `b` inputs of the PC mux; `a` carries `pc + 1`.

## Interface
- `ADDR_W`, 16: program address width; matches the 16-bit PC datapath.
- `DEPTH`, 16: loop-stack entries, a power of two, at least 2.

- `clk`  in  1  core clock.
- `rst`  in  1  synchronous, active-high reset.
- `instr_valid`  in  1  `instr`/`pc` hold a fetched instruction this cycle.
- `instr`  in  8  fetched instruction byte.
- `pc`  in  ADDR_W  address of `instr`.
- `cell_is_zero`  in  1  current data cell == 8'h00.
- `jump`  out  1  PC mux select: 1 selects `jump_target`, 0 selects `pc + 1`.
- `jump_target`  out  ADDR_W  branch destination.
- `skip`  out  1  core must not execute `instr` (suppress data/pointer/IO effects).
- `depth`  out  $clog2(DEPTH)+1  current stack occupancy.
- `err_overflow`  out  1  sticky: push attempted with `depth == DEPTH`.
- `err_underflow`  out  1  sticky: `]` executed with `depth == 0`.

## Operation
- Opcodes: `[` = 8'h5B, `]` = 8'h5D. All other bytes are "other".
- States: RUN, SKIP, ERR. Reset puts the block in RUN, with `sp = 0`, `skip_cnt = 0` and both error flags at 0.
- When `instr_valid` = 0: no state change; `jump = 0`.
- RUN, `[`:
  - If `cell_is_zero`: go to SKIP with `skip_cnt = 1`; no push.
  - Otherwise push `pc`. If `depth == DEPTH`: set `err_overflow`, go to ERR, do not push.
- RUN, `]`:
  - `depth == 0`: set `err_underflow`, go to ERR.
  - `!cell_is_zero`: `jump = 1`, `jump_target = top + 1`; stack unchanged.
  - Otherwise pop; `jump = 0`.
- RUN, other: no effect.
- SKIP, `[`: `skip_cnt++`.
- SKIP, `]`: `skip_cnt--`. When it reaches 0, go to RUN; the stack is untouched. `cell_is_zero` is ignored in SKIP.
- SKIP, other: no effect.
- ERR: absorbing until `rst`; `jump = 0`, `skip = 1`.
- `skip` = (state != RUN) || (state == RUN && `instr_valid` && `instr` is `[` or `]`). Brackets never have datapath effects.
- `skip_cnt` is ADDR_W bits wide and cannot exceed program length. `top + 1` wraps modulo 2^ADDR_W.
- `jump_target` = `top + 1` whenever `depth > 0`, otherwise 0. Its value is don't-care while `jump = 0`.

## Timing
- `jump`, `jump_target` and `skip` are combinational from the current inputs, the registered state and the stack top. They are valid in the same cycle as `instr_valid`, giving zero-latency branching for a single-cycle core.
- Stack push/pop, `skip_cnt`, state, `depth` and error flags update on the rising `clk` edge after the triggering instruction.
- A pushed address is visible as `top` in the next cycle, so back-to-back `[` `]` works.
- Reset mid-SKIP or mid-loop clears everything on that edge. Outputs read `jump = 0`, `skip = 0` (for a non-bracket `instr`), `depth = 0` and both errors 0 from the following cycle.
- Both error flags can never be set in one cycle; the first error wins and ERR blocks any further updates.

## Structure
- Shared package/header `bf_pkg`: opcode constants `OP_LBRACK`, `OP_RBRACK` (plus the other six BF opcodes for the decoder) and state encodings `ST_RUN`, `ST_SKIP`, `ST_ERR`.
- Sub-module `bf_loop_stack`: a DEPTH × ADDR_W register LIFO.
  - Inputs: `push`, `pop`, `din`.
  - Outputs: `top`, `depth`, `full`, `empty`.
  - Synchronous reset. `top` reads combinationally.
- `bf_loop_unit` holds the FSM, `skip_cnt` and error flags.

## Test plan
- Nonzero loop: `[` at pc 0x0010 with cell ≠ 0 → `depth` becomes 1. Then `]` at 0x0014 with cell ≠ 0 → `jump = 1`, `jump_target = 0x0011`. Then `]` with cell = 0 → `jump = 0`, `depth` becomes 0.
- Zero-entry skip: `[` with cell = 0, then stream `+ [ - ] >` → `skip = 1` on every byte. After the outer `]`, the state is RUN, the next `+` gives `skip = 0`, and `depth` stays 0.
- Nesting: push `[` at 0x0100, 0x0200, 0x0300 → `depth = 3`. `]` with cell ≠ 0 → `jump_target = 0x0301`. Pop once → the next `]` targets 0x0201.
- Overflow: DEPTH+1 consecutive `[` with cell ≠ 0 → `err_overflow = 1` after the last edge, `depth = DEPTH`, `skip = 1`. Any further `]` gives `jump = 0`.
- Underflow: `]` at reset with cell ≠ 0 → `err_underflow = 1`, ERR. Asserting `rst` for one cycle → all outputs return to their reset values.
- Gaps and reset mid-skip: with `instr_valid = 0` for 3 cycles between `[` and `]`, state and `depth` stay unchanged. Asserting `rst` while in SKIP with `skip_cnt = 2` → the next `+` gives `skip = 0`.
